// File: rtl/neuron_scheduler.sv
// Four-neuron integrate-and-fire scheduler with a round-robin spike output port.
// A slot pointer visits one neuron per cycle while run is high. Each visit either
// increments the neuron's counter or fires it: the counter clears and a pending
// spike is recorded. An IDLE/SEND arbiter drains pending spikes one at a time
// through a valid/ready handshake.
module neuron_scheduler #(
  parameter logic [2:0] THRESH_DEFAULT = 3'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [2:0] cfg_thresh,
  input  logic       spike_ready,
  output logic       spike_valid,
  output logic [1:0] spike_id,
  output logic [1:0] slot,
  output logic       overflow
);

  typedef enum logic {IDLE, SEND} state_t;

  logic [2:0] count  [4];
  logic [2:0] thresh [4];
  logic [3:0] pending;
  logic [1:0] last_grant;
  state_t     state;

  logic       visit_blocked;
  logic       fire;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [1:0] cand;

  // A configuration write to the visited neuron wins over the visit itself.
  always_comb begin
    visit_blocked = cfg_we && (cfg_addr == slot);
    fire          = run && !visit_blocked && (count[slot] >= thresh[slot]);
  end

  // Round-robin search starting one past the last granted neuron (only in IDLE).
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant;
    cand        = last_grant;
    if (state == IDLE) begin
      for (int k = 1; k <= 4; k++) begin
        cand = last_grant + 2'(k);
        if (!grant_valid && pending[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // Neuron state: slot pointer, counters, thresholds, pending bits and overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        count[i]  <= 3'd0;
        thresh[i] <= THRESH_DEFAULT;
      end
      pending  <= 4'b0000;
      slot     <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (run) begin
        slot <= slot + 2'd1;
        if (!visit_blocked) begin
          if (fire) count[slot] <= 3'd0;
          else      count[slot] <= count[slot] + 3'd1;
        end
      end
      if (cfg_we) begin
        thresh[cfg_addr] <= cfg_thresh;
        count[cfg_addr]  <= 3'd0;
      end
      // A fire landing on a still-pending neuron loses its event, unless that
      // same bit is being granted right now, in which case it simply re-arms.
      if (fire && pending[slot] && !(grant_valid && grant_idx == slot))
        overflow <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (fire && slot == 2'(i))
          pending[i] <= 1'b1;
        else if (grant_valid && grant_idx == 2'(i))
          pending[i] <= 1'b0;
      end
    end
  end

  // Output arbiter FSM: grant in IDLE, hold the offer in SEND until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 2'd3;
      spike_valid <= 1'b0;
      spike_id    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            spike_id    <= grant_idx;
            spike_valid <= 1'b1;
            last_grant  <= grant_idx;
            state       <= SEND;
          end
        end
        SEND: begin
          if (spike_ready) begin
            spike_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_scheduler.sv
// Testbench for neuron_scheduler: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural model of the scheduler.
module tb_neuron_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [2:0] cfg_thresh;
  logic       spike_ready;
  logic       spike_valid;
  logic [1:0] spike_id;
  logic [1:0] slot;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int m_count [4];
  int m_thresh[4];
  int m_pend  [4];
  int m_slot, m_last, m_id, m_valid, m_ovf;

  neuron_scheduler #(.THRESH_DEFAULT(3'd4)) dut (
    .clk(clk), .reset(reset), .run(run), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_thresh(cfg_thresh), .spike_ready(spike_ready), .spike_valid(spike_valid),
    .spike_id(spike_id), .slot(slot), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the scheduler's rules.
  task automatic modelStep(input int r, input int rn, input int we, input int addr,
                           input int th, input int rdy);
    int g, f;
    if (r != 0) begin
      for (int i = 0; i < 4; i++) begin
        m_count[i] = 0; m_thresh[i] = 4; m_pend[i] = 0;
      end
      m_slot = 0; m_last = 3; m_id = 0; m_valid = 0; m_ovf = 0;
      return;
    end
    g = -1;
    if (m_valid == 0)
      for (int k = 1; k <= 4; k++)
        if (g < 0 && m_pend[(m_last + k) % 4] != 0) g = (m_last + k) % 4;
    f = -1;
    if (rn != 0 && !(we != 0 && addr == m_slot) && m_count[m_slot] >= m_thresh[m_slot])
      f = m_slot;
    if (rn != 0 && !(we != 0 && addr == m_slot))
      m_count[m_slot] = (f >= 0) ? 0 : (m_count[m_slot] + 1) % 8;
    if (we != 0) begin
      m_thresh[addr] = th; m_count[addr] = 0;
    end
    if (f >= 0 && m_pend[f] != 0 && g != f) m_ovf = 1;
    if (g >= 0) m_pend[g] = 0;
    if (f >= 0) m_pend[f] = 1;
    if (m_valid == 0) begin
      if (g >= 0) begin
        m_id = g; m_valid = 1; m_last = g;
      end
    end else if (rdy != 0) begin
      m_valid = 0;
    end
    if (rn != 0) m_slot = (m_slot + 1) % 4;
  endtask

  // Drive one cycle of inputs, advance the model, and step past the clock edge.
  task automatic applyStimulus(input int r, input int rn, input int we, input int addr,
                               input int th, input int rdy);
    @(negedge clk);
    reset = 1'(r); run = 1'(rn); cfg_we = 1'(we);
    cfg_addr = 2'(addr); cfg_thresh = 3'(th); spike_ready = 1'(rdy);
    modelStep(r, rn, we, addr, th, rdy);
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the model.
  task automatic checkOutput(input string tag);
    tests++;
    assert (spike_valid === 1'(m_valid)) else begin
      fails++; $error("[TB] FAIL %s spike_valid observed=%0b expected=%0d", tag, spike_valid, m_valid);
    end
    tests++;
    assert (spike_id === 2'(m_id)) else begin
      fails++; $error("[TB] FAIL %s spike_id observed=%0d expected=%0d", tag, spike_id, m_id);
    end
    tests++;
    assert (slot === 2'(m_slot)) else begin
      fails++; $error("[TB] FAIL %s slot observed=%0d expected=%0d", tag, slot, m_slot);
    end
    tests++;
    assert (overflow === 1'(m_ovf)) else begin
      fails++; $error("[TB] FAIL %s overflow observed=%0b expected=%0d", tag, overflow, m_ovf);
    end
  endtask

  // Fixed-value check for timing points stated directly in terms of cycle numbers.
  task automatic checkConst(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++; $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(1, 1, 1, 2, 0, 1);
    checkOutput("reset");
    checkConst("reset_valid", {1'b0, spike_valid}, 2'd0);
    checkConst("reset_slot", slot, 2'd0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_thresh = 3'd0; spike_ready = 1'b0;
    modelStep(1, 0, 0, 0, 0, 0);

    // Free-running with ready high: neuron 0 fires at cycle 16, offered at 18.
    doReset();
    for (int c = 0; c < 48; c++) begin
      applyStimulus(0, 1, 0, 0, 0, 1);
      checkOutput("freerun");
      if (c == 16) checkConst("freerun_c17_valid", {1'b0, spike_valid}, 2'd0);
      if (c == 17) begin
        checkConst("freerun_c18_valid", {1'b0, spike_valid}, 2'd1);
        checkConst("freerun_c18_id", spike_id, 2'd0);
      end
    end

    // Stalled downstream: offer held, second fire of neuron 1 at cycle 37 overflows.
    doReset();
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("stall");
      if (c == 36) checkConst("stall_c37_ovf", {1'b0, overflow}, 2'd0);
      if (c == 37) checkConst("stall_c38_ovf", {1'b0, overflow}, 2'd1);
      if (c >= 17) checkConst("stall_id", spike_id, 2'd0);
    end

    // Reset during an offer drops it and clears overflow.
    doReset();
    checkConst("midsend_ovf", {1'b0, overflow}, 2'd0);
    checkConst("midsend_id", spike_id, 2'd0);

    // Threshold 0 written to neuron 2 on its own visit: fires at cycle 6, 10, ...
    for (int c = 0; c < 24; c++) begin
      applyStimulus(0, 1, (c == 2) ? 1 : 0, 2, 0, 1);
      checkOutput("thresh0");
      if (c == 6) checkConst("thresh0_c7_valid", {1'b0, spike_valid}, 2'd0);
      if (c == 7) begin
        checkConst("thresh0_c8_valid", {1'b0, spike_valid}, 2'd1);
        checkConst("thresh0_c8_id", spike_id, 2'd2);
      end
    end

    // Run paused for 5 cycles: neuron 0's first fire shifts from 16 to 21.
    doReset();
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, (c >= 10 && c < 15) ? 0 : 1, 0, 0, 0, 1);
      checkOutput("pause");
      if (c == 21) checkConst("pause_c22_valid", {1'b0, spike_valid}, 2'd0);
      if (c == 22) begin
        checkConst("pause_c23_valid", {1'b0, spike_valid}, 2'd1);
        checkConst("pause_c23_id", spike_id, 2'd0);
      end
    end

    // Low thresholds on neurons 1 and 3 with a slow consumer exercise round-robin.
    doReset();
    applyStimulus(0, 0, 1, 1, 1, 0); checkOutput("rr_cfg1");
    applyStimulus(0, 0, 1, 3, 1, 0); checkOutput("rr_cfg3");
    for (int c = 0; c < 60; c++) begin
      applyStimulus(0, 1, 0, 0, 0, (c % 5 == 0) ? 1 : 0);
      checkOutput("rr");
    end

    // Randomized traffic with occasional resets and reconfiguration.
    doReset();
    for (int c = 0; c < 800; c++) begin
      applyStimulus(($urandom_range(63) == 0) ? 1 : 0,
                    ($urandom_range(3) != 0) ? 1 : 0,
                    ($urandom_range(7) == 0) ? 1 : 0,
                    int'($urandom_range(3)),
                    int'($urandom_range(7)),
                    int'($urandom_range(1)));
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
